// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ALU between two requesters.
// Guards divide-by-zero, times out a missing done flag, returns a tagged response.
module alu_op_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned TIMEOUT    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [1:0]            req0_fun,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [1:0]            req1_fun,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_fun,
    output logic                  alu_en,
    input  logic [OUT_WIDTH-1:0]  alu_out,
    input  logic                  alu_flag,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [OUT_WIDTH-1:0]  rsp_data,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic                  busy
);

    localparam int unsigned       CNT_W    = 4;
    localparam logic [1:0]        FUN_DIV  = 2'b11;
    localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                state, state_n;
    logic                  prio, prio_n;
    logic [CNT_W-1:0]      cnt, cnt_n, cnt_inc;
    logic                  op_id, op_id_n;
    logic [DATA_WIDTH-1:0] alu_a_n, alu_b_n;
    logic [1:0]            alu_fun_n;
    logic                  alu_en_n;
    logic                  rsp_valid_n, rsp_id_n, rsp_err_n;
    logic [OUT_WIDTH-1:0]  rsp_data_n;
    logic                  busy_n;

    logic                  any_valid, grant;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;
    logic [1:0]            sel_fun;
    logic                  sel_div0, op_div0;

    // Grant: the lone valid requester, or the pointer's choice on contention
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? prio : req1_valid;
        sel_a     = grant ? req1_a   : req0_a;
        sel_b     = grant ? req1_b   : req0_b;
        sel_fun   = grant ? req1_fun : req0_fun;
        sel_div0  = (sel_fun == FUN_DIV) && (sel_b == '0);
        op_div0   = (alu_fun == FUN_DIV) && (alu_b == '0);
        cnt_inc   = cnt + CNT_W'(1);
    end

    assign req0_ready = (state == S_IDLE) && any_valid && !grant;
    assign req1_ready = (state == S_IDLE) && any_valid &&  grant;

    // Next state and next values of every registered output
    always_comb begin
        state_n     = state;
        prio_n      = prio;
        cnt_n       = cnt;
        op_id_n     = op_id;
        alu_a_n     = alu_a;
        alu_b_n     = alu_b;
        alu_fun_n   = alu_fun;
        alu_en_n    = 1'b0;
        rsp_valid_n = rsp_valid;
        rsp_id_n    = rsp_id;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;

        case (state)
            S_IDLE: begin
                if (any_valid) begin
                    state_n   = S_ISSUE;
                    op_id_n   = grant;
                    alu_a_n   = sel_a;
                    alu_b_n   = sel_b;
                    alu_fun_n = sel_fun;
                    // alu_en is registered, so it is raised on the accept edge
                    alu_en_n  = !sel_div0;
                end
            end
            S_ISSUE: begin
                cnt_n = '0;
                if (op_div0) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_id_n    = op_id;
                    rsp_data_n  = '1;
                    rsp_err_n   = 1'b1;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (alu_flag) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_id_n    = op_id;
                    rsp_data_n  = alu_out;
                    rsp_err_n   = 1'b0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TO_LIMIT) begin
                        state_n     = S_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_id_n    = op_id;
                        rsp_data_n  = '0;
                        rsp_err_n   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n     = S_IDLE;
                    prio_n      = ~op_id;
                    rsp_valid_n = 1'b0;
                    rsp_id_n    = 1'b0;
                    rsp_data_n  = '0;
                    rsp_err_n   = 1'b0;
                    alu_a_n     = '0;
                    alu_b_n     = '0;
                    alu_fun_n   = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            prio      <= 1'b0;
            cnt       <= '0;
            op_id     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            alu_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            prio      <= prio_n;
            cnt       <= cnt_n;
            op_id     <= op_id_n;
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            alu_fun   <= alu_fun_n;
            alu_en    <= alu_en_n;
            rsp_valid <= rsp_valid_n;
            rsp_id    <= rsp_id_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Scoreboard bench for alu_op_arbiter with a behavioural 1-cycle ALU.
module tb_alu_op_arbiter;

    localparam logic [1:0] F_ADD = 2'b00, F_SUB = 2'b01, F_MUL = 2'b10, F_DIV = 2'b11;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_fun, req1_fun;
    logic       req0_ready, req1_ready;
    logic [7:0] alu_a, alu_b;
    logic [1:0] alu_fun;
    logic       alu_en;
    logic [7:0] alu_out;
    logic       alu_flag;
    logic       rsp_valid, rsp_id, rsp_err, rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;

    typedef struct packed {
        logic       id;
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   en_count = 0;
    int   en0;
    bit   tb_prio  = 1'b0;
    bit   suppress = 1'b0;

    alu_op_arbiter #(.DATA_WIDTH(8), .OUT_WIDTH(8), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Reference result {err, data}, wrapped to 8 bits
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        logic [15:0] w;
        case (f)
            F_ADD:   w = 16'(a) + 16'(b);
            F_SUB:   w = 16'(a) - 16'(b);
            F_MUL:   w = 16'(a) * 16'(b);
            default: begin
                if (b == 8'd0) return {1'b1, 8'hFF};
                w = 16'(a / b);
            end
        endcase
        return {1'b0, w[7:0]};
    endfunction

    function automatic logic [7:0] alu_res(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        logic [8:0] m;
        m = model(a, b, f);
        return m[7:0];
    endfunction

    // Behavioural ALU: result and flag one edge after enable, cleared after
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_out  <= 8'd0;
            alu_flag <= 1'b0;
        end else if (alu_en && !suppress) begin
            alu_out  <= alu_res(alu_a, alu_b, alu_fun);
            alu_flag <= 1'b1;
        end else begin
            alu_out  <= 8'd0;
            alu_flag <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_raw(input bit id, input bit err, input logic [7:0] data);
        exp_t e;
        e.id = id; e.err = err; e.data = data;
        q.push_back(e);
        tb_prio = ~id;
    endtask

    task automatic push_exp(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        logic [8:0] m;
        m = model(a, b, f);
        push_raw(id, m[8], m[7:0]);
    endtask

    // Response monitor, sampled one unit before the rising edge
    always @(negedge CLK) begin
        exp_t e;
        #4;
        if (RST) begin
            if (alu_en) en_count++;
            check("one_ready", 32'(req0_ready & req1_ready), 0);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic drive_req(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        bit done;
        done = 1'b0;
        if (id) begin req1_a = a; req1_b = b; req1_fun = f; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_fun = f; req0_valid = 1'b1; end
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                @(posedge CLK);
                #1;
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
        if (!done) begin
            check("accept_timeout", 0, 1);
            if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        end
    endtask

    task automatic dual(input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] f0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] f1);
        if (tb_prio == 1'b0) begin push_exp(0, a0, b0, f0); push_exp(1, a1, b1, f1); end
        else                 begin push_exp(1, a1, b1, f1); push_exp(0, a0, b0, f0); end
        fork
            drive_req(0, a0, b0, f0);
            drive_req(1, a1, b1, f1);
        join
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (!busy && !rsp_valid && q.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        RST = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_fun = 2'b00;
        req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_fun = 2'b00;
        repeat (3) @(negedge CLK);
        check("rst_ctrl", 32'({alu_en, rsp_valid, busy, rsp_err, rsp_id, req0_ready, req1_ready}), 0);
        check("rst_data", 32'({alu_a, alu_b, alu_fun, rsp_data}), 0);
        RST = 1'b1;
        @(negedge CLK);

        // Single ADD with cycle-exact latency
        en0 = en_count;
        push_exp(0, 8'd20, 8'd22, F_ADD);
        drive_req(0, 8'd20, 8'd22, F_ADD);
        @(negedge CLK);
        check("t1_issue_en", 32'(alu_en), 1);
        check("t1_issue_busy", 32'(busy), 1);
        check("t1_issue_a", 32'(alu_a), 20);
        @(negedge CLK);
        check("t1_wait_en", 32'(alu_en), 0);
        check("t1_wait_valid", 32'(rsp_valid), 0);
        @(negedge CLK);
        check("t1_rsp_valid", 32'(rsp_valid), 1);
        check("t1_rsp_data", 32'(rsp_data), 42);
        @(negedge CLK);
        check("t1_done_valid", 32'(rsp_valid), 0);
        check("t1_done_busy", 32'(busy), 0);
        check("t1_en_cycles", 32'(en_count - en0), 1);
        check("t1_alu_a_clr", 32'(alu_a), 0);

        // Reset restores req0 priority
        RST = 1'b0; @(negedge CLK); RST = 1'b1; tb_prio = 1'b0; @(negedge CLK);

        // Contention rounds: req0 first, then a lone req0, then req1 first
        dual(8'd5, 8'd7, F_SUB, 8'd16, 8'd16, F_MUL);
        wait_idle();
        push_exp(0, 8'd3, 8'd4, F_ADD);
        drive_req(0, 8'd3, 8'd4, F_ADD);
        wait_idle();
        dual(8'd9, 8'd3, F_DIV, 8'd200, 8'd100, F_ADD);
        wait_idle();

        // Divide by zero never enables the ALU
        en0 = en_count;
        push_exp(1, 8'd9, 8'd0, F_DIV);
        drive_req(1, 8'd9, 8'd0, F_DIV);
        @(negedge CLK);
        check("t3_issue_en", 32'(alu_en), 0);
        check("t3_issue_busy", 32'(busy), 1);
        @(negedge CLK);
        check("t3_rsp_valid", 32'(rsp_valid), 1);
        check("t3_rsp_err", 32'(rsp_err), 1);
        wait_idle();
        check("t3_en_cycles", 32'(en_count - en0), 0);

        // Missing done flag times out after 4 WAIT cycles
        suppress = 1'b1;
        push_raw(0, 1'b1, 8'd0);
        drive_req(0, 8'd1, 8'd2, F_ADD);
        repeat (5) @(negedge CLK);
        check("t4_before_to", 32'(rsp_valid), 0);
        @(negedge CLK);
        check("t4_to_valid", 32'(rsp_valid), 1);
        check("t4_to_err", 32'(rsp_err), 1);
        @(negedge CLK);
        check("t4_busy_drop", 32'(busy), 0);
        suppress = 1'b0;
        wait_idle();

        // Response held under back-pressure while req1 waits
        rsp_ready = 1'b0;
        push_exp(0, 8'd100, 8'd7, F_DIV);
        push_exp(1, 8'd11, 8'd12, F_SUB);
        drive_req(0, 8'd100, 8'd7, F_DIV);
        req1_a = 8'd11; req1_b = 8'd12; req1_fun = F_SUB; req1_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (rsp_valid) seen = 1'b1;
        end
        check("t5_rsp_seen", 32'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 32'(rsp_valid), 1);
            check("t5_hold_data", 32'(rsp_data), 14);
            check("t5_hold_req1_ready", 32'(req1_ready), 0);
            @(negedge CLK);
        end
        rsp_ready = 1'b1;
        drive_req(1, 8'd11, 8'd12, F_SUB);
        wait_idle();

        // Reset during WAIT drops the op silently
        drive_req(0, 8'd1, 8'd1, F_ADD);
        @(negedge CLK);
        @(negedge CLK);
        check("t6_busy_before", 32'(busy), 1);
        #1 RST = 1'b0;
        #1;
        check("t6_rst_ctrl", 32'({alu_en, rsp_valid, busy, rsp_err, rsp_id}), 0);
        check("t6_rst_data", 32'({alu_a, alu_b, alu_fun, rsp_data}), 0);
        @(negedge CLK);
        RST = 1'b1; tb_prio = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("t6_no_rsp", 32'(rsp_valid), 0);
        end
        dual(8'd50, 8'd60, F_ADD, 8'd7, 8'd3, F_MUL);
        wait_idle();

        check("queue_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
